// File: rtl/chinx_pcsel_ctrl.sv
// ---------------------------------------------------------------------------
// chinx_pcsel_ctrl
//
// Next-PC source controller for the IF stage. Chooses the stage-1 next-PC
// select and supplies the hold (epc), interrupt vector (ipc) and saved return
// (rpc) addresses. An interrupt walks through four phases: a flush/drain
// window, a single vector-fetch cycle, the service routine, and the return.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous reset, active low
//   stall_i    in   1        pipeline hazard: hold the IF PC this cycle
//   branch_i   in   1        taken branch resolved this cycle
//   baddr_i    in   ADDR_W   branch target
//   pc_i       in   ADDR_W   current IF PC
//   irq_i      in   NIRQ     level-sensitive interrupt requests
//   eret_i     in   1        return-from-interrupt decoded
//   bsrc_o     out  3        next-PC select: 0 pc+1, 1 branch, 2 epc, 3 ipc, 4 rpc
//   epc_o      out  ADDR_W   hold address (current PC)
//   ipc_o      out  ADDR_W   vector address of the latched irq
//   rpc_o      out  ADDR_W   saved return address
//   flush_o    out  1        squash younger in-flight instructions
//   int_ack_o  out  NIRQ     one-hot, one-cycle acknowledge of the taken irq
//   busy_o     out  1        interrupt sequence in progress
// ---------------------------------------------------------------------------
module chinx_pcsel_ctrl #(
    parameter int                ADDR_W       = 32,
    parameter int                NIRQ         = 4,
    parameter int                DRAIN_CYCLES = 2,
    parameter logic [ADDR_W-1:0] IVEC_BASE    = ADDR_W'(32'h0000_0040),
    parameter int                VEC_STRIDE   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] baddr_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [NIRQ-1:0]   irq_i,
    input  logic              eret_i,
    output logic [2:0]        bsrc_o,
    output logic [ADDR_W-1:0] epc_o,
    output logic [ADDR_W-1:0] ipc_o,
    output logic [ADDR_W-1:0] rpc_o,
    output logic              flush_o,
    output logic [NIRQ-1:0]   int_ack_o,
    output logic              busy_o
);

    localparam int ID_W  = (NIRQ > 1) ? $clog2(NIRQ) : 1;
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_VECT  = 2'd2;
    localparam logic [1:0] S_SERV  = 2'd3;

    localparam logic [2:0] BSRC_PC1 = 3'd0;
    localparam logic [2:0] BSRC_BR  = 3'd1;
    localparam logic [2:0] BSRC_EPC = 3'd2;
    localparam logic [2:0] BSRC_IPC = 3'd3;
    localparam logic [2:0] BSRC_RPC = 3'd4;

    logic [1:0]        r_state;
    logic              r_ien;
    logic [ADDR_W-1:0] r_ret;
    logic [ID_W-1:0]   r_id;
    logic [CNT_W-1:0]  r_cnt;

    logic [ID_W-1:0]   w_win;
    logic              w_take;
    logic [2:0]        w_bsrc_run;
    logic [2:0]        w_bsrc;
    logic              w_flush;
    logic [NIRQ-1:0]   w_ack;
    logic [ADDR_W-1:0] w_ipc;

    // Lowest-numbered request wins: scan from the top so lower indices overwrite.
    always_comb begin
        w_win = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq_i[i]) begin
                w_win = ID_W'(i);
            end
        end
    end

    // A stalled cycle cannot take: the held PC would not be the right return point.
    assign w_take     = (|irq_i) & r_ien & ~stall_i;
    assign w_bsrc_run = branch_i ? BSRC_BR : (stall_i ? BSRC_EPC : BSRC_PC1);

    always_comb begin
        w_bsrc  = w_bsrc_run;
        w_flush = 1'b0;
        w_ack   = '0;
        case (r_state)
            S_RUN: begin
                if (w_take) begin
                    w_bsrc  = BSRC_EPC;
                    w_flush = 1'b1;
                end
            end
            S_DRAIN: begin
                w_bsrc  = BSRC_EPC;
                w_flush = 1'b1;
            end
            S_VECT: begin
                // Vector fetch overrides any stall request.
                w_bsrc = BSRC_IPC;
                for (int i = 0; i < NIRQ; i++) begin
                    w_ack[i] = (r_id == ID_W'(i));
                end
            end
            S_SERV: begin
                // eret beats a same-cycle branch; a stall makes it wait on the held PC.
                if (eret_i) begin
                    if (stall_i) begin
                        w_bsrc = BSRC_EPC;
                    end else begin
                        w_bsrc  = BSRC_RPC;
                        w_flush = 1'b1;
                    end
                end
            end
            default: begin
                w_bsrc = w_bsrc_run;
            end
        endcase
    end

    assign w_ipc = IVEC_BASE + (ADDR_W'(r_id) * ADDR_W'(VEC_STRIDE));

    // Combinational outputs are forced quiet while reset is held.
    assign bsrc_o    = rst ? w_bsrc  : BSRC_PC1;
    assign flush_o   = rst & w_flush;
    assign int_ack_o = rst ? w_ack   : '0;
    assign busy_o    = rst & (r_state != S_RUN);
    assign epc_o     = pc_i;
    assign ipc_o     = w_ipc;
    assign rpc_o     = r_ret;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_ien   <= 1'b1;
            r_ret   <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_take) begin
                        r_id    <= w_win;
                        r_cnt   <= CNT_W'(DRAIN_CYCLES - 1);
                        // The IF instruction is squashed, so return to it (or to
                        // the branch target if a branch resolved on the take cycle).
                        r_ret   <= branch_i ? baddr_i : pc_i;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!stall_i) begin
                        if (r_cnt == '0) begin
                            r_state <= S_VECT;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_VECT: begin
                    r_ien   <= 1'b0;
                    r_state <= S_SERV;
                end
                S_SERV: begin
                    if (eret_i && !stall_i) begin
                        r_ien   <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chinx_pcsel_ctrl.sv
module tb_chinx_pcsel_ctrl;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] baddr_i;
    logic [31:0] pc_i;
    logic [3:0]  irq_i;
    logic        eret_i;
    logic [2:0]  bsrc_o;
    logic [31:0] epc_o;
    logic [31:0] ipc_o;
    logic [31:0] rpc_o;
    logic        flush_o;
    logic [3:0]  int_ack_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    int ack_seen = 0;

    // Reference model: an interrupt is "active" from the take until eret.
    // drain_left counts un-stalled drain cycles still owed before the vector cycle.
    bit          m_active;
    bit          m_vectored;
    int          m_drain_left;
    int          m_id;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    chinx_pcsel_ctrl #(
        .ADDR_W      (32),
        .NIRQ        (4),
        .DRAIN_CYCLES(D),
        .IVEC_BASE   (32'h0000_0040),
        .VEC_STRIDE  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall_i  (stall_i),
        .branch_i (branch_i),
        .baddr_i  (baddr_i),
        .pc_i     (pc_i),
        .irq_i    (irq_i),
        .eret_i   (eret_i),
        .bsrc_o   (bsrc_o),
        .epc_o    (epc_o),
        .ipc_o    (ipc_o),
        .rpc_o    (rpc_o),
        .flush_o  (flush_o),
        .int_ack_o(int_ack_o),
        .busy_o   (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic model_clear();
        m_active     = 1'b0;
        m_vectored   = 1'b0;
        m_drain_left = 0;
        m_id         = 0;
        m_ret        = 32'h0;
    endtask

    // Drive one cycle of inputs, check all outputs against the model, clock once.
    // xb / xa: additional literal expectations for bsrc / int_ack (-1 = none).
    task automatic step(input logic st, input logic br, input logic [31:0] ba,
                        input logic [31:0] pc, input logic [3:0] irq, input logic er,
                        input int xb, input int xa);
        logic [2:0]  e_bsrc;
        logic        e_flush;
        logic [3:0]  e_ack;
        logic        e_busy;
        logic [2:0]  normal;
        bit          take;
        int          lowest;
        bit          n_active;
        bit          n_vect;
        int          n_left;
        int          n_id;
        logic [31:0] n_ret;

        stall_i  = st;
        branch_i = br;
        baddr_i  = ba;
        pc_i     = pc;
        irq_i    = irq;
        eret_i   = er;
        #1;
        if (!rst) model_clear();

        lowest = -1;
        for (int i = 0; i < 4; i++) if (lowest < 0 && irq[i]) lowest = i;
        normal  = br ? 3'd1 : (st ? 3'd2 : 3'd0);
        take    = (irq != 4'b0) && !st;
        e_bsrc  = normal;
        e_flush = 1'b0;
        e_ack   = 4'b0;
        e_busy  = m_active;
        if (!rst) begin
            e_bsrc = 3'd0;
            e_busy = 1'b0;
        end else if (!m_active) begin
            if (take) begin
                e_bsrc  = 3'd2;
                e_flush = 1'b1;
            end
        end else if (!m_vectored && m_drain_left > 0) begin
            e_bsrc  = 3'd2;
            e_flush = 1'b1;
        end else if (!m_vectored) begin
            e_bsrc = 3'd3;
            e_ack  = 4'b1 << m_id;
        end else if (er) begin
            e_bsrc  = st ? 3'd2 : 3'd4;
            e_flush = !st;
        end

        chk("bsrc",  {29'b0, bsrc_o}, {29'b0, e_bsrc});
        chk("flush", {31'b0, flush_o}, {31'b0, e_flush});
        chk("ack",   {28'b0, int_ack_o}, {28'b0, e_ack});
        chk("busy",  {31'b0, busy_o}, {31'b0, e_busy});
        chk("ipc",   ipc_o, 32'h40 + 32'(4 * m_id));
        chk("rpc",   rpc_o, m_ret);
        chk("epc",   epc_o, pc);
        if (xb >= 0) chk("bsrc_dir", {29'b0, bsrc_o}, xb);
        if (xa >= 0) chk("ack_dir", {28'b0, int_ack_o}, xa);
        if (int_ack_o != 4'b0) ack_seen++;

        n_active = m_active;
        n_vect   = m_vectored;
        n_left   = m_drain_left;
        n_id     = m_id;
        n_ret    = m_ret;
        if (rst) begin
            if (!m_active) begin
                if (take) begin
                    n_active = 1'b1;
                    n_vect   = 1'b0;
                    n_left   = D;
                    n_id     = lowest;
                    n_ret    = br ? ba : pc;
                end
            end else if (!m_vectored && m_drain_left > 0) begin
                if (!st) n_left = m_drain_left - 1;
            end else if (!m_vectored) begin
                n_vect = 1'b1;
            end else if (er && !st) begin
                n_active = 1'b0;
            end
        end

        @(posedge clk);
        if (rst) begin
            m_active     = n_active;
            m_vectored   = n_vect;
            m_drain_left = n_left;
            m_id         = n_id;
            m_ret        = n_ret;
        end else begin
            model_clear();
        end
        #1;
    endtask

    initial begin
        model_clear();
        rst = 1'b0;
        step(0, 0, 32'h0, 32'h100, 4'b0, 0, 0, 0);
        step(1, 1, 32'h55, 32'h100, 4'b1, 1, 0, 0);

        // Reset release, idle
        rst = 1'b1;
        step(0, 0, 32'h0, 32'h100, 4'b0, 0, 0, 0);
        chk("rst_ipc", ipc_o, 32'h40);
        chk("rst_rpc", rpc_o, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);

        // Stalls then branch-with-stall
        step(1, 0, 32'h0, 32'h104, 4'b0, 0, 2, -1);
        step(1, 0, 32'h0, 32'h108, 4'b0, 0, 2, -1);
        step(1, 0, 32'h0, 32'h10c, 4'b0, 0, 2, -1);
        step(1, 1, 32'h180, 32'h110, 4'b0, 0, 1, -1);

        // irq 0110 at T, pc 0x200
        step(0, 0, 32'h0, 32'h200, 4'b0110, 0, 2, 0);
        chk("t3_rpc", rpc_o, 32'h200);
        chk("t3_ipc", ipc_o, 32'h44);
        step(0, 0, 32'h0, 32'h201, 4'b0110, 0, 2, 0);
        step(0, 0, 32'h0, 32'h202, 4'b0110, 0, 2, 0);
        step(0, 0, 32'h0, 32'h203, 4'b0110, 0, 3, 2);

        // In service: no nesting, eret waits on stall, then returns
        step(0, 0, 32'h0, 32'h44, 4'b0001, 0, 0, 0);
        step(0, 1, 32'h60, 32'h48, 4'b0001, 0, 1, 0);
        step(1, 0, 32'h0, 32'h4c, 4'b0001, 1, 2, 0);
        step(0, 1, 32'h70, 32'h4c, 4'b0001, 1, 4, 0);
        chk("t5_busy", {31'b0, busy_o}, 32'h0);
        step(0, 0, 32'h0, 32'h200, 4'b0001, 0, 2, 0);
        step(0, 0, 32'h0, 32'h201, 4'b0001, 0, 2, 0);
        step(0, 0, 32'h0, 32'h202, 4'b0001, 0, 2, 0);
        step(0, 0, 32'h0, 32'h203, 4'b0001, 0, 3, 1);
        step(0, 0, 32'h0, 32'h40, 4'b0000, 1, 4, 0);

        // irq with same-cycle branch, stall during drain
        step(0, 1, 32'h380, 32'h300, 4'b1000, 0, 2, 0);
        chk("t4_rpc", rpc_o, 32'h380);
        step(1, 0, 32'h0, 32'h301, 4'b1000, 0, 2, 0);
        step(0, 0, 32'h0, 32'h302, 4'b1000, 0, 2, 0);
        step(0, 0, 32'h0, 32'h303, 4'b1000, 0, 2, 0);
        step(0, 0, 32'h0, 32'h304, 4'b1000, 0, 3, 8);
        step(0, 0, 32'h0, 32'h4c, 4'b0000, 1, 4, 0);

        // Reset during drain, irq still asserted afterwards
        step(0, 0, 32'h0, 32'h400, 4'b0100, 0, 2, 0);
        step(0, 0, 32'h0, 32'h401, 4'b0100, 0, 2, 0);
        rst = 1'b0;
        step(1, 1, 32'h90, 32'h402, 4'b0100, 0, 0, 0);
        chk("t6_busy", {31'b0, busy_o}, 32'h0);
        rst = 1'b1;
        ack_seen = 0;
        step(0, 0, 32'h0, 32'h500, 4'b0100, 0, 2, 0);
        step(0, 0, 32'h0, 32'h501, 4'b0100, 0, 2, 0);
        step(0, 0, 32'h0, 32'h502, 4'b0100, 0, 2, 0);
        step(0, 0, 32'h0, 32'h503, 4'b0100, 0, 3, 4);
        step(0, 0, 32'h0, 32'h48, 4'b0000, 0, 0, 0);
        step(0, 0, 32'h0, 32'h4c, 4'b0000, 0, 0, 0);
        chk("t6_ack_once", ack_seen, 1);
        step(0, 0, 32'h0, 32'h50, 4'b0000, 1, 4, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       st, br, er;
            logic [3:0] irq;
            rst = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
            st  = ($urandom_range(3) == 0);
            br  = ($urandom_range(3) == 0);
            er  = ($urandom_range(4) == 0);
            irq = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0;
            step(st, br, $urandom, $urandom, irq, er, -1, -1);
        end
        rst = 1'b1;
        step(0, 0, 32'h0, 32'h600, 4'b0, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
